// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue handshake bundle: redirect/hazard inputs, the request and
// response channels to the AXI bridge, and the instruction channel to ID.
//   master : the fetch queue itself (drives req_* and out_*)
//   slave  : the surrounding pipeline / bridge
interface ifu_fetch_queue_if #(
  parameter int unsigned AW = 64
);
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic [63:0]   rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_pc;

  modport master (
    input  redirect_valid, redirect_pc, stall, req_ready, rsp_valid, rsp_data, out_ready,
    output req_valid, req_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, req_ready, rsp_valid, rsp_data, out_ready,
    input  req_valid, req_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue. Issues sequential doubleword fetches (up to
// MAX_OUTSTANDING in flight) and buffers returned instructions in a
// QDEPTH-entry queue feeding decode. Redirects flush the queue and retire
// stale in-flight responses by epoch tag.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   fq       : ifu_fetch_queue_if.master (redirect/stall in, req/rsp to the
//              bridge, out_* to ID)
module ifu_fetch_queue #(
  parameter int unsigned AW              = 64,
  parameter logic [63:0] RESET_PC        = 64'h8000_0000,
  parameter int unsigned QDEPTH          = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  ifu_fetch_queue_if.master fq
);
  localparam int unsigned QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned QCW = $clog2(QDEPTH) + 1;
  localparam int unsigned MPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned MCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned OW  = ((QCW > MCW) ? QCW : MCW) + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          epoch;
  } meta_t;

  typedef struct packed {
    logic [31:0]   inst;
    logic [AW-1:0] pc;
  } qent_t;

  function automatic logic [QPW-1:0] qinc(input logic [QPW-1:0] p);
    return (p == QPW'(QDEPTH - 1)) ? '0 : p + QPW'(1);
  endfunction

  function automatic logic [MPW-1:0] minc(input logic [MPW-1:0] p);
    return (p == MPW'(MAX_OUTSTANDING - 1)) ? '0 : p + MPW'(1);
  endfunction

  meta_t meta_mem [MAX_OUTSTANDING];
  qent_t q_mem    [QDEPTH];

  logic [AW-1:0]  pc_q, pc_d;
  logic           epoch_q, epoch_d;
  logic           drop_all_q, drop_all_d;
  logic           req_valid_q, req_valid_d;
  logic [AW-1:0]  req_addr_q, req_addr_d;
  logic           req_stale_q, req_stale_d;
  logic [MPW-1:0] mwr_ptr_q, mwr_ptr_d, mrd_ptr_q, mrd_ptr_d;
  logic [MCW-1:0] infl_q, infl_d;
  logic [QPW-1:0] qwr_ptr_q, qwr_ptr_d, qrd_ptr_q, qrd_ptr_d;
  logic [QCW-1:0] qcnt_q, qcnt_d;

  logic           acc, rsp_keep, deq, issue, out_vld, push_ep;
  logic [OW-1:0]  occ;
  meta_t          meta_hd;

  always_comb begin
    acc      = req_valid_q & fq.req_ready;
    meta_hd  = meta_mem[mrd_ptr_q];
    out_vld  = (qcnt_q != '0);
    // A redirect flushes the queue, so nothing lands in it and nothing leaves.
    rsp_keep = fq.rsp_valid & (meta_hd.epoch == epoch_q) & ~drop_all_q & ~fq.redirect_valid;
    deq      = out_vld & fq.out_ready & ~fq.redirect_valid;
    occ      = OW'(qcnt_q) + OW'(infl_q);
    // Issue is also held off while drop_all drains, otherwise fresh requests
    // could keep inflight_count above zero and starve the pipeline forever.
    issue    = ~req_valid_q & ~fq.stall & (occ < OW'(QDEPTH)) &
               (infl_q < MCW'(MAX_OUTSTANDING)) & ~fq.redirect_valid & ~drop_all_q;

    epoch_d  = epoch_q ^ fq.redirect_valid;
    // A request issued before a redirect (or accepted in the redirect cycle)
    // is tagged so it can never match the post-edge epoch.
    push_ep  = (req_stale_q | fq.redirect_valid) ? ~epoch_d : epoch_d;

    pc_d = pc_q;
    if (fq.redirect_valid)       pc_d = fq.redirect_pc;
    else if (acc && !req_stale_q) pc_d = pc_q + AW'(4);

    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    if (acc) req_valid_d = 1'b0;
    else if (issue) begin
      req_valid_d = 1'b1;
      req_addr_d  = {pc_q[AW-1:3], 3'b000};
    end
    req_stale_d = req_valid_q & ~acc & (req_stale_q | fq.redirect_valid);

    mwr_ptr_d = acc ? minc(mwr_ptr_q) : mwr_ptr_q;
    mrd_ptr_d = fq.rsp_valid ? minc(mrd_ptr_q) : mrd_ptr_q;
    infl_d    = infl_q;
    case ({acc, fq.rsp_valid})
      2'b10:   infl_d = infl_q + MCW'(1);
      2'b01:   infl_d = infl_q - MCW'(1);
      default: infl_d = infl_q;
    endcase

    qwr_ptr_d = rsp_keep ? qinc(qwr_ptr_q) : qwr_ptr_q;
    qrd_ptr_d = deq ? qinc(qrd_ptr_q) : qrd_ptr_q;
    qcnt_d    = qcnt_q;
    case ({rsp_keep, deq})
      2'b10:   qcnt_d = qcnt_q + QCW'(1);
      2'b01:   qcnt_d = qcnt_q - QCW'(1);
      default: qcnt_d = qcnt_q;
    endcase
    if (fq.redirect_valid) begin
      qwr_ptr_d = '0;
      qrd_ptr_d = '0;
      qcnt_d    = '0;
    end

    // With a one-bit epoch, a second redirect while older-epoch responses are
    // still outstanding would make them look current again. The head is the
    // oldest entry, so if anything in flight is stale the head is.
    drop_all_d = drop_all_q;
    if (fq.redirect_valid && infl_q != '0 && meta_hd.epoch != epoch_q) drop_all_d = 1'b1;
    else if (infl_d == '0)                                             drop_all_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC[AW-1:0];
      epoch_q     <= 1'b0;
      drop_all_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_stale_q <= 1'b0;
      mwr_ptr_q   <= '0;
      mrd_ptr_q   <= '0;
      infl_q      <= '0;
      qwr_ptr_q   <= '0;
      qrd_ptr_q   <= '0;
      qcnt_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      drop_all_q  <= drop_all_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_stale_q <= req_stale_d;
      mwr_ptr_q   <= mwr_ptr_d;
      mrd_ptr_q   <= mrd_ptr_d;
      infl_q      <= infl_d;
      qwr_ptr_q   <= qwr_ptr_d;
      qrd_ptr_q   <= qrd_ptr_d;
      qcnt_q      <= qcnt_d;
    end
  end

  // Storage arrays need no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (acc) meta_mem[mwr_ptr_q] <= '{pc: pc_q, epoch: push_ep};
    if (rsp_keep)
      q_mem[qwr_ptr_q] <= '{inst: (meta_hd.pc[2] ? fq.rsp_data[63:32] : fq.rsp_data[31:0]),
                            pc:   meta_hd.pc};
  end

  // A response with nothing in flight means the bridge and queue disagree.
  always_ff @(posedge clk) begin
    if (!rst && fq.rsp_valid) assert (infl_q != '0);
  end

  assign fq.req_valid = req_valid_q;
  assign fq.req_addr  = req_addr_q;
  assign fq.out_valid = out_vld;
  assign fq.out_inst  = out_vld ? q_mem[qrd_ptr_q].inst : 32'h0000_0013;
  assign fq.out_pc    = out_vld ? q_mem[qrd_ptr_q].pc   : '0;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
  localparam int AW = 64;
  localparam logic [63:0] RDATA = {32'h0020_0093, 32'h0010_0093};
  localparam logic [63:0] I0 = 64'h0010_0093;
  localparam logic [63:0] I1 = 64'h0020_0093;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_queue_if #(.AW(AW)) ifc ();

  ifu_fetch_queue #(
    .AW(AW), .RESET_PC(64'h8000_0000), .QDEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fq (ifc)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          lat   = 2;
  int          due_q[$];
  logic [63:0] acc_log[$];
  int          nbase;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock with a fixed-latency in-order bridge model. Responses for a
  // request accepted at edge e are presented for sampling at edge e+lat.
  task automatic tick();
    logic        acc, rst_s;
    logic [63:0] addr;
    acc   = ifc.req_valid && ifc.req_ready;
    addr  = ifc.req_addr;
    rst_s = rst;
    @(posedge clk);
    #1;
    cyc++;
    ifc.rsp_valid = 1'b0;
    if (rst_s) due_q.delete();
    else begin
      if (acc) begin
        due_q.push_back(cyc + lat);
        acc_log.push_back(addr);
      end
      if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
        ifc.rsp_valid = 1'b1;
        void'(due_q.pop_front());
      end
    end
  endtask

  task automatic redirect(input logic [63:0] tgt);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = tgt;
    tick();
    ifc.redirect_valid = 1'b0;
  endtask

  logic [63:0] dpc  [4] = '{64'h8000_0004, 64'h8000_0008, 64'h8000_000C, 64'h8000_0010};
  logic [63:0] dinst[4] = '{I1, I0, I1, I0};

  initial begin
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.stall          = 1'b0;
    ifc.req_ready      = 1'b0;
    ifc.rsp_valid      = 1'b0;
    ifc.rsp_data       = RDATA;
    ifc.out_ready      = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_req_valid", 64'(ifc.req_valid), 64'd0);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_inst",  64'(ifc.out_inst),  64'h13);
    chk("rst_out_pc",    ifc.out_pc,         64'd0);

    // Sequential fetch with ID blocked: credit caps accepts at QDEPTH
    rst = 1'b0;
    ifc.req_ready = 1'b1;
    repeat (20) tick();
    chk("fill_acc_cnt", 64'(acc_log.size()), 64'd4);
    chk("fill_addr0",   acc_log[0], 64'h8000_0000);
    chk("fill_addr1",   acc_log[1], 64'h8000_0000);
    chk("fill_addr2",   acc_log[2], 64'h8000_0008);
    chk("fill_addr3",   acc_log[3], 64'h8000_0008);
    chk("fill_req_off", 64'(ifc.req_valid), 64'd0);
    chk("fill_head_pc", ifc.out_pc, 64'h8000_0000);
    chk("fill_head_in", 64'(ifc.out_inst), I0);

    // One pop frees exactly one credit
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk("pop_head_pc", ifc.out_pc, 64'h8000_0004);
    chk("pop_head_in", 64'(ifc.out_inst), I1);
    repeat (10) tick();
    chk("pop_acc_cnt", 64'(acc_log.size()), 64'd5);
    chk("pop_addr4",   acc_log[4], 64'h8000_0010);
    chk("pop_req_off", 64'(ifc.req_valid), 64'd0);

    // Drain in order with issue stalled
    ifc.stall     = 1'b1;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc",   ifc.out_pc, dpc[i]);
      chk("drain_inst", 64'(ifc.out_inst), dinst[i]);
      tick();
    end
    ifc.out_ready = 1'b0;
    chk("empty_valid", 64'(ifc.out_valid), 64'd0);
    chk("empty_inst",  64'(ifc.out_inst),  64'h13);
    chk("empty_pc",    ifc.out_pc,         64'd0);

    // Pending request held stable under stall until accepted
    ifc.stall     = 1'b0;
    ifc.req_ready = 1'b0;
    tick();
    chk("hold_valid0", 64'(ifc.req_valid), 64'd1);
    chk("hold_addr0",  ifc.req_addr, 64'h8000_0010);
    ifc.stall = 1'b1;
    repeat (3) tick();
    chk("hold_valid1", 64'(ifc.req_valid), 64'd1);
    chk("hold_addr1",  ifc.req_addr, 64'h8000_0010);
    ifc.req_ready = 1'b1;
    tick();
    repeat (4) tick();
    chk("stall_req_off", 64'(ifc.req_valid), 64'd0);
    chk("stall_acc_cnt", 64'(acc_log.size()), 64'd6);
    chk("stall_head_pc", ifc.out_pc, 64'h8000_0014);
    chk("stall_head_in", 64'(ifc.out_inst), I1);

    // Redirect with two requests in flight
    lat       = 6;
    ifc.stall = 1'b0;
    repeat (5) tick();
    chk("redir_acc_cnt", 64'(acc_log.size()), 64'd8);
    redirect(64'h8000_1000);
    lat = 2;
    chk("redir_flush", 64'(ifc.out_valid), 64'd0);
    repeat (5) tick();
    chk("redir_stale_drop", 64'(ifc.out_valid), 64'd0);
    tick();
    chk("redir_new_addr", acc_log[8], 64'h8000_1000);
    chk("redir_valid",    64'(ifc.out_valid), 64'd1);
    chk("redir_pc",       ifc.out_pc, 64'h8000_1000);
    chk("redir_inst",     64'(ifc.out_inst), I0);

    // Redirect coinciding with an accept and a response
    ifc.stall     = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (12) tick();
    ifc.out_ready = 1'b0;
    redirect(64'h8000_2000);
    ifc.stall = 1'b0;
    repeat (3) tick();
    chk("coinc_rsp_pending", 64'(ifc.rsp_valid), 64'd1);
    chk("coinc_acc_pending", 64'(ifc.req_valid), 64'd1);
    redirect(64'h8000_3000);
    chk("coinc_y_addr", acc_log[acc_log.size()-1], 64'h8000_2000);
    chk("coinc_flush",  64'(ifc.out_valid), 64'd0);
    repeat (3) tick();
    chk("coinc_drop", 64'(ifc.out_valid), 64'd0);
    tick();
    chk("coinc_pc0",   ifc.out_pc, 64'h8000_3000);
    chk("coinc_inst0", 64'(ifc.out_inst), I0);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    tick();
    chk("coinc_pc1",   ifc.out_pc, 64'h8000_3004);
    chk("coinc_inst1", 64'(ifc.out_inst), I1);

    // Reset mid-operation: two queued, one in flight
    ifc.stall     = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (12) tick();
    ifc.out_ready = 1'b0;
    ifc.stall     = 1'b0;
    repeat (6) tick();
    chk("pre_rst_valid", 64'(ifc.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("mid_rst_req_valid", 64'(ifc.req_valid), 64'd0);
    chk("mid_rst_out_inst",  64'(ifc.out_inst),  64'h13);
    chk("mid_rst_out_pc",    ifc.out_pc,         64'd0);
    nbase = acc_log.size();
    lat   = 6;
    rst   = 1'b0;
    repeat (5) tick();
    chk("post_rst_cnt",  64'(acc_log.size()), 64'(nbase + 2));
    chk("post_rst_addr", acc_log[nbase], 64'h8000_0000);

    // Back-to-back redirects while the first epoch is still in flight
    redirect(64'h8000_4000);
    redirect(64'h8000_5000);
    lat = 2;
    repeat (4) tick();
    chk("b2b_drop", 64'(ifc.out_valid), 64'd0);
    repeat (3) tick();
    chk("b2b_valid", 64'(ifc.out_valid), 64'd1);
    chk("b2b_pc",    ifc.out_pc, 64'h8000_5000);
    chk("b2b_inst",  64'(ifc.out_inst), I0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised successor to the single-entry IF stage.
- Issues sequential instruction fetches to the AXI bridge, with up to MAX_OUTSTANDING requests in flight, and buffers returned instructions in a QDEPTH-entry queue feeding decode.
- On a branch/jump redirect it flushes the queue and discards stale in-flight responses using an epoch bit, instead of injecting NOPs.
- Sits between the branch unit, the hazard unit and ID.

Parameters:
- AW, 64: PC/address width.
- RESET_PC, 64'h80000000: PC after reset.
- QDEPTH, 4: instruction queue entries (power of two, ≥2).
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered fetch requests (power of two, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  AW  redirect target
- stall  in  1  hazard hold; blocks new request issue only
- req_valid  out  1  fetch request valid
- req_ready  in  1  bridge accepts request
- req_addr  out  AW  fetch address, 8-byte aligned (pc with [2:0] cleared)
- rsp_valid  in  1  fetch data returned; in order; always accepted
- rsp_data  in  64  returned doubleword
- out_valid  out  1  queue head valid to ID
- out_ready  in  1  ID allowin
- out_inst  out  32  head instruction
- out_pc  out  AW  head PC

Behaviour:
- Reset (rst high at clk edge):
  - pc=RESET_PC, epoch=0, queue empty, in-flight metadata FIFO empty.
  - req_valid=0, out_valid=0, out_inst=32'h13, out_pc=0.
  - rst asserted mid-operation drops everything, including pending responses. The bridge is reset by the same rst.
- Credit and issue:
  - credit = QDEPTH − (queue_count + inflight_count).
  - Start a request when !req_valid_hold && !stall && credit>0 && inflight_count<MAX_OUTSTANDING && !redirect_valid.
  - Once req_valid is high, req_valid and req_addr stay stable until req_ready. stall does not retract a pending request.
- Request accept (req_valid&&req_ready):
  - Push {pc, epoch} into the metadata FIFO and increment inflight_count.
  - pc <= pc+4, wrapping at 2^AW.
  - req_valid may reassert the next cycle (one request per cycle maximum; latency ≥1 cycle from issue to accept).
- Response (rsp_valid):
  - Pop the metadata FIFO and decrement inflight_count.
  - If entry.epoch==epoch, push {inst, entry.pc} into the queue, where inst = entry.pc[2] ? rsp_data[63:32] : rsp_data[31:0]. Otherwise discard.
  - Credit guarantees the queue never overflows.
  - rsp_valid while inflight_count==0 is illegal; assert in simulation.
- Queue output:
  - out_valid = queue not empty; out_inst/out_pc = head fields.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle keep count unchanged.
  - When empty, out_inst=32'h13, out_pc=0.
  - Zero-latency bypass is not required: a response is visible on out_* the cycle after rsp_valid.
- Redirect (redirect_valid high at edge):
  - epoch <= ~epoch; pc <= redirect_pc; queue flushed (out_valid=0 next cycle).
  - A same-cycle out_ready pop is ignored; the flush wins.
  - A same-cycle response carrying the old epoch is discarded.
  - A same-cycle request accept is recorded with the old epoch, so its response is later discarded, and pc is overwritten by redirect_pc (not +4).
  - A pending unaccepted request keeps its old address and stays until accepted; its response is dropped.
  - The first post-redirect request issues no earlier than the cycle after the redirect.
  - Back-to-back redirects: each flips epoch. At most MAX_OUTSTANDING ≤ 2^1 epochs can be in flight only if MAX_OUTSTANDING aliasing is avoided. Therefore, while inflight_count>0 and the entry epoch already equals ~epoch (a prior redirect is still draining), a second redirect also sets drop_all, which discards every response until inflight_count reaches 0.
- Counters: queue_count is log2(QDEPTH)+1 bits; inflight_count is log2(MAX_OUTSTANDING)+1 bits; pointers wrap modulo depth.

Test Plan:
- Reset then req_ready=1, responses 2 cycles later with rsp_data={32'h00200093,32'h00100093}:
  - req_addr 0x80000000, 0x80000000, 0x80000008…
  - out sequence (0x80000000, 0x00100093), (0x80000004, 0x00200093), in order.
- out_ready=0 held:
  - Exactly QDEPTH=4 requests accepted, then req_valid stays 0.
  - One out_ready pulse → exactly one new request.
- Redirect to 0x80001000 with 2 requests in flight:
  - Both responses discarded, queue empty the next cycle.
  - Next req_addr=0x80001000, first out_pc=0x80001000.
- stall=1 while req_valid=1 and req_ready=0:
  - req_valid/req_addr stay stable until req_ready.
  - No new request while stall stays high.
- Redirect in the same cycle as a request accept and a response:
  - Both the accepted request's response and the same-cycle response are dropped.
  - pc=redirect_pc, no +4.
- rst asserted with queue half full and 1 request in flight:
  - Next cycle out_valid=0, req_valid=0, out_inst=32'h13.
  - First request after rst release has addr 0x80000000.
